// File: rtl/dram_ctrl.sv
// Closed-page DRAM controller: one ACT/RW/PRE sequence per request plus periodic refresh.
// Every pin and user output is a flop loaded from the decode of the next state.
module dram_ctrl #(
    parameter int unsigned NUMBER_OF_COLUMNS = 8,
    parameter int unsigned NUMBER_OF_ROWS    = 128,
    parameter int unsigned NUMBER_OF_BANKS   = 8,
    parameter int unsigned DRAM_DATA_WIDTH   = 2,
    parameter int unsigned REFRESH_INTERVAL  = 1000,
    localparam int unsigned COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH),
    localparam int unsigned ROW_WIDTH       = $clog2(NUMBER_OF_ROWS),
    localparam int unsigned BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS),
    localparam int unsigned U_ADDR_WIDTH    = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH,
    localparam int unsigned DRAM_ADDR_WIDTH = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
    input  logic                       dram_clk,
    input  logic                       dram_rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [U_ADDR_WIDTH-1:0]    req_addr,
    input  logic [DRAM_DATA_WIDTH-1:0] req_wr_data,
    output logic                       rsp_valid,
    output logic [DRAM_DATA_WIDTH-1:0] rsp_rd_data,
    output logic                       refresh_busy,
    output logic                       dram_cs_n,
    output logic                       dram_ras_n,
    output logic                       dram_cas_n,
    output logic                       dram_we_n,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    output logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    output logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic                       dram_clk_en,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    input  logic                       dram_refresh_done
);

    localparam int unsigned CNT_WIDTH = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_ACT, S_RW, S_PRE, S_REF, S_REF_WAIT
    } state_t;

    state_t                     state_q, state_n;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_n;
    logic                       pending_q, pending_n;
    logic                       wrap_c, accept_c;
    logic                       we_q;
    logic [U_ADDR_WIDTH-1:0]    addr_q;
    logic [DRAM_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                 cmd_q, cmd_d;
    logic [DRAM_ADDR_WIDTH-1:0] addr_d;
    logic [BANK_ID_WIDTH-1:0]   bank_d;
    logic [DRAM_DATA_WIDTH-1:0] wdata_d, rd_d;
    logic                       ready_d, busy_d, rsp_d;

    logic [ROW_WIDTH-1:0]       req_row_c, row_q;
    logic [BANK_ID_WIDTH-1:0]   req_bank_c, bank_q;
    logic [COLUMN_WIDTH-1:0]    col_q;

    assign req_row_c  = req_addr[COLUMN_WIDTH +: ROW_WIDTH];
    assign req_bank_c = req_addr[COLUMN_WIDTH + ROW_WIDTH +: BANK_ID_WIDTH];
    assign col_q      = addr_q[COLUMN_WIDTH-1:0];
    assign row_q      = addr_q[COLUMN_WIDTH +: ROW_WIDTH];
    assign bank_q     = addr_q[COLUMN_WIDTH + ROW_WIDTH +: BANK_ID_WIDTH];

    assign wrap_c   = (cnt_q == CNT_WIDTH'(REFRESH_INTERVAL - 1));
    assign cnt_n    = wrap_c ? '0 : cnt_q + CNT_WIDTH'(1);
    assign accept_c = req_valid && req_ready;

    assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd_q;

    // State, free-running refresh counter and pending flag
    always_ff @(posedge dram_clk or posedge dram_rst) begin
        if (dram_rst) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pending_q <= pending_n;
        end
    end

    always_ff @(posedge dram_clk or posedge dram_rst) begin
        if (dram_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wr_data;
        end
    end

    // A wrap this cycle counts as pending already, so IDLE can go straight to REF
    always_comb begin
        state_n   = state_q;
        pending_n = pending_q | wrap_c;
        case (state_q)
            S_RST:      state_n = S_IDLE;
            S_IDLE: begin
                if (pending_q || wrap_c) begin
                    state_n   = S_REF;
                    pending_n = 1'b0;
                end else if (accept_c) begin
                    state_n = S_ACT;
                end
            end
            S_ACT:      state_n = S_RW;
            S_RW:       state_n = S_PRE;
            S_PRE:      state_n = S_IDLE;
            S_REF:      state_n = S_REF_WAIT;
            S_REF_WAIT: if (dram_refresh_done) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Next values of the output flops, decoded from the state being entered
    always_comb begin
        cmd_d   = CMD_NOP;
        addr_d  = dram_addr;
        bank_d  = dram_bank_id;
        wdata_d = dram_wr_data;
        busy_d  = 1'b0;
        case (state_n)
            S_ACT: begin
                cmd_d  = CMD_ACT;
                addr_d = DRAM_ADDR_WIDTH'(req_row_c);
                bank_d = req_bank_c;
            end
            S_RW: begin
                cmd_d   = we_q ? CMD_WRITE : CMD_READ;
                addr_d  = DRAM_ADDR_WIDTH'(col_q);
                bank_d  = bank_q;
                wdata_d = wdata_q;
            end
            S_PRE: begin
                cmd_d  = CMD_PRE;
                addr_d = DRAM_ADDR_WIDTH'(row_q);
                bank_d = bank_q;
            end
            S_REF: begin
                cmd_d  = CMD_REF;
                busy_d = 1'b1;
            end
            S_REF_WAIT: busy_d = 1'b1;
            default: ;
        endcase
        ready_d = (state_n == S_IDLE) && !pending_n && (cnt_n != CNT_WIDTH'(REFRESH_INTERVAL - 1));
        rsp_d   = (state_q == S_PRE);
        rd_d    = (state_q == S_PRE && !we_q) ? dram_rd_data : rsp_rd_data;
    end

    always_ff @(posedge dram_clk or posedge dram_rst) begin
        if (dram_rst) begin
            cmd_q        <= CMD_DESEL;
            dram_addr    <= '0;
            dram_bank_id <= '0;
            dram_wr_data <= '0;
            dram_clk_en  <= 1'b0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rd_data  <= '0;
            refresh_busy <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            dram_addr    <= addr_d;
            dram_bank_id <= bank_d;
            dram_wr_data <= wdata_d;
            dram_clk_en  <= 1'b1;
            req_ready    <= ready_d;
            rsp_valid    <= rsp_d;
            rsp_rd_data  <= rd_d;
            refresh_busy <= busy_d;
        end
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 Parameters SHALL be as follows:
- NUMBER_OF_COLUMNS, default 8: bits per row.
- NUMBER_OF_ROWS, default 128: rows per bank.
- NUMBER_OF_BANKS, default 8: number of banks.
- DRAM_DATA_WIDTH, default 2: data bits per column access.
- REFRESH_INTERVAL, default 1000: clock cycles between refresh commands.
REQ-002 Derived widths (not overridden) SHALL be as follows:
- COLUMN_WIDTH = clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH).
- ROW_WIDTH = clog2(NUMBER_OF_ROWS).
- BANK_ID_WIDTH = clog2(NUMBER_OF_BANKS).
- U_ADDR_WIDTH = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH.
- DRAM_ADDR_WIDTH = max(ROW_WIDTH, COLUMN_WIDTH).
REQ-003 Ports SHALL be (name direction width meaning):
- dram_clk  in  1  single clock, all logic on rising edge.
- dram_rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  user request valid.
- req_ready  out  1  controller accepts request.
- req_we  in  1  1=write, 0=read.
- req_addr  in  U_ADDR_WIDTH  {bank, row, col}.
- req_wr_data  in  DRAM_DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rd_data  out  DRAM_DATA_WIDTH  read data, valid with rsp_valid on reads.
- refresh_busy  out  1  refresh sequence in progress.
- dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n  out  1 each  DRAM command.
- dram_addr  out  DRAM_ADDR_WIDTH  row or column address.
- dram_bank_id  out  BANK_ID_WIDTH  bank.
- dram_wr_data  out  DRAM_DATA_WIDTH  write data to DRAM.
- dram_clk_en  out  1  DRAM clock enable.
- dram_rd_data  in  DRAM_DATA_WIDTH  DRAM read data, valid the cycle after READ.
- dram_refresh_done  in  1  DRAM refresh-complete pulse.

Function
REQ-004 Command encoding {cs_n,ras_n,cas_n,we_n} SHALL be: NOP 0111, ACTIVATE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, DESELECT 1111.
REQ-005 All dram_* outputs and all user outputs SHALL be driven from flops; the command for an FSM state SHALL appear on the pins during exactly the cycle(s) the FSM occupies that state.
REQ-006 FSM states SHALL be IDLE, ACT, RW, PRE, REF, REF_WAIT; IDLE, REF_WAIT and every cycle outside the reset state SHALL drive NOP unless stated otherwise, keeping cs_n=0.
REQ-007 req_ready SHALL be 1 only in IDLE with refresh_pending=0; a request SHALL be accepted on req_valid&&req_ready, latching req_we, req_addr and req_wr_data.
REQ-008 Transitions SHALL be closed-page:
- IDLE→ACT on accept: ACTIVATE with addr=row, bank=bank.
- ACT→RW: READ or WRITE with addr=col zero-extended, dram_wr_data=latched data.
- RW→PRE: PRECHARGE with addr=row, bank=bank.
- PRE→IDLE.
REQ-009 On reads, dram_rd_data SHALL be sampled at the end of the PRE cycle.
REQ-010 rsp_valid SHALL pulse 1 cycle, in the cycle after PRE, for both reads and writes; rsp_rd_data SHALL hold the sampled read data, and hold its last value otherwise.
REQ-011 Accept-to-rsp_valid latency SHALL be 4 cycles; maximum throughput SHALL be one request per 4 cycles.
REQ-012 A refresh counter SHALL count 0..REFRESH_INTERVAL-1 and wrap, free-running in all states; on wrap it SHALL set refresh_pending.
REQ-013 A wrap while refresh_pending is already set SHALL leave it set, with no second refresh queued.
REQ-014 In IDLE, refresh_pending=1 SHALL take priority over req_valid (req_ready=0): IDLE→REF issues REFRESH for 1 cycle and clears refresh_pending.
REQ-015 The refresh sequence SHALL continue REF→REF_WAIT; REF_WAIT SHALL drive NOP until dram_refresh_done=1, then go to IDLE.
REQ-016 refresh_busy SHALL be 1 in REF and REF_WAIT.
REQ-017 A pending refresh SHALL NOT interrupt an in-flight ACT/RW/PRE sequence.
REQ-018 dram_refresh_done outside REF_WAIT SHALL be ignored.

Reset
REQ-019 dram_rst SHALL asynchronously force:
- FSM=IDLE-reset, counter=0, refresh_pending=0.
- Command pins 1111, dram_addr/dram_bank_id/dram_wr_data=0, dram_clk_en=0.
- req_ready=0, rsp_valid=0, rsp_rd_data=0, refresh_busy=0.
REQ-020 On the first edge after reset deassertion, the controller SHALL enter IDLE with NOP and dram_clk_en=1; dram_clk_en SHALL then stay 1.
REQ-021 Reset mid-request or mid-refresh SHALL drop the operation with no rsp_valid.

Verification
REQ-022 Write bank=3 row=5 col=2 data=2'b10, then read the same address: pin sequence SHALL be 0011/0100/0010 then 0011/0101/0010; the read SHALL give rsp_rd_data=2'b10, 4 cycles after accept.
REQ-023 With REFRESH_INTERVAL=16 and no requests: REFRESH 0001 SHALL be issued on the 16th cycle after reset, followed by NOPs until dram_refresh_done, with refresh_busy high throughout.
REQ-024 Counter wrap in the same cycle as req_valid in IDLE: req_ready=0 and REFRESH SHALL be issued first; the request SHALL be accepted after done.
REQ-025 Wrap during RW: PRECHARGE SHALL complete, rsp_valid SHALL pulse, then REFRESH SHALL be issued.
REQ-026 dram_rst asserted during ACT: outputs SHALL go to reset values immediately, with no rsp_valid afterwards.
REQ-027 Back-to-back reads with req_valid held: accepts SHALL be exactly 4 cycles apart.
